alu_rr_sequencer: RTL and testbench
===================================

// Module: alu_rr_sequencer
// PURPOSE
//   Shares one 32-bit ALU between two requesters using round-robin arbitration.
//   Each requester issues (a, b, ctrl) with a valid/ready handshake. The block sequences
//   each op through IDLE -> EXEC -> RESP and returns the result with the requester ID.
//   It sits between the issuing units and the shared ALU instance (ports alu_*).
// PARAMETERS
//   WIDTH   32  operand/result width; must match the ALU datapath
//   CNT_W   16  width of the completed-operation counter
// PORTS
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous reset, active high
//   req0_valid   in   1      requester 0 has an op
//   req0_ready   out  1      requester 0 op accepted this cycle
//   req0_a       in   WIDTH  requester 0 operand a
//   req0_b       in   WIDTH  requester 0 operand b
//   req0_ctrl    in   3      requester 0 ALU op code
//   req1_*       --   --     identical set for requester 1 (valid, ready, a, b, ctrl)
//   alu_a        out  WIDTH  operand a to shared ALU
//   alu_b        out  WIDTH  operand b to shared ALU
//   alu_ctrl     out  3      op code to shared ALU
//   alu_y        in   WIDTH  ALU result, combinational from alu_a/b/ctrl
//   alu_zero     in   1      ALU zero flag
//   resp_valid   out  1      response available
//   resp_ready   in   1      consumer takes response
//   resp_id      out  1      requester the response belongs to
//   resp_y       out  WIDTH  registered result
//   resp_zero    out  1      registered zero flag
//   resp_err     out  1      op code was illegal; no ALU op was performed
//   ops_count    out  CNT_W  number of completed responses, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset: state=IDLE; last_grant=1, so req0 wins the first tie; resp_valid=0;
//     resp_id=0; resp_y=0; resp_zero=0; resp_err=0; ops_count=0; alu_a/b/ctrl=0;
//     req*_ready=0. Reset aborts any in-flight op with no response.
//   Legal ctrl codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed).
//     Codes 011, 100 and 101 are illegal.
//   IDLE:
//     - grant = the only valid requester. If both are valid, grant = !last_grant.
//     - reqN_ready=1 combinationally for the granted requester only, and only in IDLE.
//     - On handshake: latch a, b, ctrl and id into operand regs; set last_grant=id;
//       go to EXEC.
//     - No valid requester: stay in IDLE.
//   EXEC (1 cycle):
//     - alu_a/b/ctrl driven from operand regs; outside EXEC they hold 0.
//     - Legal op: capture alu_y -> resp_y, alu_zero -> resp_zero, resp_err=0.
//     - Illegal op: resp_y=0, resp_zero=1, resp_err=1; alu_ctrl is still driven 000.
//     - Go to RESP.
//   RESP:
//     - resp_valid=1; resp_id, resp_y, resp_zero and resp_err are held stable.
//     - On resp_valid & resp_ready: ops_count++ (wraps), resp_valid=0 next cycle,
//       go to IDLE.
//     - resp_ready=0 stalls indefinitely; no new request is accepted.
//   Latency: handshake edge -> resp_valid high 2 cycles later.
//     Minimum issue interval is 3 cycles per op.
//   Requests arriving during EXEC/RESP wait with ready=0; requesters hold their inputs.
//   A requester dropping valid before ready is legal and loses its slot.
//   Fairness: with both requesters continuously valid, grants strictly alternate.
//   The combinational ready path depends only on state, valid and last_grant,
//     never on resp_ready.
// TESTING
//   T1 req0 ADD a=5,b=7 -> req0_ready 1 cycle; 2 cycles later resp_valid,id=0,y=12,zero=0
//   T2 req1 SUB a=9,b=9 -> resp id=1,y=0,zero=1; SLT a=-1,b=1 -> y=1; SLT a=3,b=-2 -> y=0
//   T3 both valid continuously, resp_ready=1 -> grant order 0,1,0,1; ops_count=4 after 12 cycles
//   T4 resp_ready=0 for 5 cycles in RESP -> outputs stable, no ready asserted, then one completion
//   T5 req0 ctrl=100 -> resp_err=1,y=0,zero=1,alu_ctrl stays 000; ops_count increments
//   T6 rst in EXEC -> next cycle all outputs at reset values, no resp_valid, req0 wins next tie

Source files
------------

// File: rtl/alu_rr_sequencer.sv
// Round-robin sharing of one combinational ALU between two requesters: IDLE -> EXEC -> RESP.
// Latency: handshake -> response 2 cycles; a stalled response (resp_ready=0) blocks all new grants.
module alu_rr_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_y,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [CNT_W-1:0] ops_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [2:0]       r_op_ctrl;
  logic             r_op_id;
  logic             r_resp_id;
  logic [WIDTH-1:0] r_resp_y;
  logic             r_resp_zero;
  logic             r_resp_err;
  logic [CNT_W-1:0] r_ops_count;

  logic             w_grant_id;
  logic             w_accept;
  logic             w_op_legal;
  logic             w_resp_done;

  // On a tie the requester that did not win last time gets the slot.
  assign w_grant_id  = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign req0_ready  = (r_state == S_IDLE) && req0_valid && !w_grant_id;
  assign req1_ready  = (r_state == S_IDLE) && req1_valid &&  w_grant_id;
  assign w_accept    = req0_ready || req1_ready;
  assign w_resp_done = (r_state == S_RESP) && resp_ready;
  assign w_op_legal  = r_op_ctrl inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  always_comb begin
    w_state_nxt = r_state;
    alu_a       = '0;
    alu_b       = '0;
    alu_ctrl    = 3'b000;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC: begin
        alu_a       = r_op_a;
        alu_b       = r_op_b;
        alu_ctrl    = w_op_legal ? r_op_ctrl : 3'b000;
        w_state_nxt = S_RESP;
      end
      S_RESP: if (resp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_ctrl    <= 3'b000;
      r_op_id      <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_y     <= '0;
      r_resp_zero  <= 1'b0;
      r_resp_err   <= 1'b0;
      r_ops_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a       <= w_grant_id ? req1_a    : req0_a;
        r_op_b       <= w_grant_id ? req1_b    : req0_b;
        r_op_ctrl    <= w_grant_id ? req1_ctrl : req0_ctrl;
        r_op_id      <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == S_EXEC) begin
        r_resp_id   <= r_op_id;
        r_resp_y    <= w_op_legal ? alu_y    : '0;
        r_resp_zero <= w_op_legal ? alu_zero : 1'b1;
        r_resp_err  <= !w_op_legal;
      end
      if (w_resp_done) r_ops_count <= r_ops_count + CNT_W'(1);
    end
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_id    = r_resp_id;
  assign resp_y     = r_resp_y;
  assign resp_zero  = r_resp_zero;
  assign resp_err   = r_resp_err;
  assign ops_count  = r_ops_count;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a behavioural ALU on the alu_* port.
module tb_alu_rr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_err;
  logic [31:0] resp_y;
  logic [15:0] ops_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_ops  = 0;
  int grants[$];

  always #5 clk = ~clk;

  alu_rr_sequencer #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_y(resp_y),
    .resp_zero(resp_zero), .resp_err(resp_err), .ops_count(ops_count)
  );

  always_comb begin
    alu_y = 32'd0;
    case (alu_ctrl)
      3'b000: alu_y = alu_a & alu_b;
      3'b001: alu_y = alu_a | alu_b;
      3'b010: alu_y = alu_a + alu_b;
      3'b110: alu_y = alu_a - alu_b;
      3'b111: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = 32'd0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c; end
    else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c; end
  endtask

  // Single op from an idle DUT, resp_ready held high.
  task automatic run_op(input string tag, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c, input logic [31:0] ey, input bit ez, input bit ee);
    logic [2:0] exp_ctrl;
    exp_ctrl = (c inside {3'b011, 3'b100, 3'b101}) ? 3'b000 : c;
    @(posedge clk); #1;
    drive(id, a, b, c);
    @(negedge clk);
    chk({tag, "_rdy"},  {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    chk({tag, "_nrdy"}, {31'd0, id ? req0_ready : req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({tag, "_alu_a"},    alu_a, a);
    chk({tag, "_alu_ctrl"}, {29'd0, alu_ctrl}, {29'd0, exp_ctrl});
    chk({tag, "_vld_exec"}, {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"},  {31'd0, resp_valid}, 32'd1);
    chk({tag, "_id"},   {31'd0, resp_id}, {31'd0, id});
    chk({tag, "_y"},    resp_y, ey);
    chk({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, ez});
    chk({tag, "_err"},  {31'd0, resp_err}, {31'd0, ee});
    @(posedge clk); #1;
    exp_ops++;
    chk({tag, "_vld_done"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, ops_count}, exp_ops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",  {31'd0, resp_valid}, 32'd0);
    chk("rst_y",    resp_y, 32'd0);
    chk("rst_cnt",  {16'd0, ops_count}, 32'd0);
    chk("rst_alu",  alu_a | alu_b | {29'd0, alu_ctrl}, 32'd0);
    chk("rst_flags", {29'd0, resp_id, resp_zero, resp_err}, 32'd0);
    rst = 1'b0;

    // T1 / T2 / T5
    run_op("t1_add", 1'b0, 32'd5, 32'd7, 3'b010, 32'd12, 1'b0, 1'b0);
    run_op("t2_sub", 1'b1, 32'd9, 32'd9, 3'b110, 32'd0, 1'b1, 1'b0);
    run_op("t2_slt_a", 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111, 32'd1, 1'b0, 1'b0);
    run_op("t2_slt_b", 1'b1, 32'd3, 32'hFFFF_FFFE, 3'b111, 32'd0, 1'b1, 1'b0);
    run_op("t2_or", 1'b0, 32'h00F0, 32'h0F00, 3'b001, 32'h0FF0, 1'b0, 1'b0);

    // T3: both continuously valid, last grant was req0 so req1 leads
    @(posedge clk); #1;
    drive(1'b0, 32'd1, 32'd2, 3'b010);
    drive(1'b1, 32'd4, 32'd8, 3'b001);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (resp_valid) chk("t3_y", resp_y, resp_id ? 32'd12 : 32'd3);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_ops += 4;
    chk("t3_ngrants", grants.size(), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk("t3_order", grants[i], (i % 2 == 0) ? 32'd1 : 32'd0);
    chk("t3_cnt", {16'd0, ops_count}, exp_ops);

    // T4: response stall
    @(posedge clk); #1;
    resp_ready = 1'b0;
    drive(1'b0, 32'hF0F0, 32'hFF00, 3'b000);
    @(negedge clk);
    chk("t4_rdy", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    drive(1'b0, 32'd1, 32'd1, 3'b010);
    drive(1'b1, 32'd1, 32'd1, 3'b010);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_vld",  {31'd0, resp_valid}, 32'd1);
      chk("t4_y",    resp_y, 32'hF000);
      chk("t4_id",   {31'd0, resp_id}, 32'd0);
      chk("t4_nrdy", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("t4_cnt",  {16'd0, ops_count}, exp_ops);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    exp_ops++;
    chk("t4_done_vld", {31'd0, resp_valid}, 32'd0);
    chk("t4_done_cnt", {16'd0, ops_count}, exp_ops);
    @(posedge clk); #1;
    chk("t4_once_cnt", {16'd0, ops_count}, exp_ops);

    // T5: illegal op code
    run_op("t5_ill", 1'b0, 32'd5, 32'd5, 3'b100, 32'd0, 1'b1, 1'b1);
    run_op("t5_ill101", 1'b0, 32'd6, 32'd3, 3'b101, 32'd0, 1'b1, 1'b1);

    // T6: reset in EXEC after a req0 grant (a tie would now favour req1 without reset)
    @(posedge clk); #1;
    drive(1'b0, 32'd10, 32'd20, 3'b010);
    @(negedge clk);
    chk("t6_rdy", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ops = 0;
    chk("t6_vld", {31'd0, resp_valid}, 32'd0);
    chk("t6_alu", alu_a | alu_b | {29'd0, alu_ctrl}, 32'd0);
    chk("t6_cnt", {16'd0, ops_count}, 32'd0);
    chk("t6_resp", resp_y | {29'd0, resp_id, resp_zero, resp_err}, 32'd0);
    @(posedge clk); #1;
    chk("t6_novld", {31'd0, resp_valid}, 32'd0);
    drive(1'b0, 32'd2, 32'd3, 3'b010);
    drive(1'b1, 32'd7, 32'd7, 3'b110);
    @(negedge clk);
    chk("t6_tie", {30'd0, req0_ready, req1_ready}, 32'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("t6_id", {31'd0, resp_id}, 32'd0);
    chk("t6_y",  resp_y, 32'd5);
    @(posedge clk); #1;
    exp_ops++;
    chk("t6_cnt2", {16'd0, ops_count}, exp_ops);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
